// File: rtl/shim_inject_arbiter.sv
// Packet-granular round-robin arbiter feeding the single SiliconNet shim injection port.
// Latency: head eligible in IDLE at cycle T is forwarded at T+1; phits then pass through combinationally.
// Backpressure: granted client's ready follows ~shim_full_in[locked dst]; all other clients see ready=0.

package shim_inject_pkg;
    localparam int SN_PORT_W = 3;
    localparam int SN_DATA_W = 32;

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [SN_PORT_W-1:0] dst_port;
        logic [SN_DATA_W-1:0] data;
    } SwitchInterface;
endpackage

module shim_inject_arbiter
    import shim_inject_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_PORTS   = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  SwitchInterface                 client_ifc_in [NUM_CLIENTS],
    input  logic [NUM_CLIENTS-1:0]         client_valid_in,
    output logic [NUM_CLIENTS-1:0]         client_ready_out,
    output SwitchInterface                 shim_ifc_out,
    output logic                           shim_wren_out,
    input  logic [NUM_PORTS-1:0]           shim_full_in,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_out,
    output logic                           busy_out,
    output logic                           err_protocol_out
);

    localparam int CW  = $clog2(NUM_CLIENTS);
    localparam int CW1 = CW + 1;
    localparam int GW  = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_grant;
    logic [CW-1:0]        r_rr_ptr;
    logic [SN_PORT_W-1:0] r_dst;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [CW-1:0]        w_grant_nxt;
    logic [CW-1:0]        w_rr_nxt;
    logic [SN_PORT_W-1:0] w_dst_nxt;
    logic [GW-1:0]        w_gap_nxt;
    logic                 w_err_nxt;

    logic [NUM_CLIENTS-1:0] w_elig;
    logic                   w_bad_head;
    logic                   w_found;
    logic [CW-1:0]          w_winner;
    logic [CW1-1:0]         w_cand;
    logic [NUM_CLIENTS-1:0] w_ready;
    logic                   w_accept;
    SwitchInterface         w_ifc;

    // Per-client eligibility: valid packet head whose destination has room; flag heads missing 'first'.
    always_comb begin
        w_elig     = '0;
        w_bad_head = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_elig[i] = client_valid_in[i] & client_ifc_in[i].first
                        & ~shim_full_in[client_ifc_in[i].dst_port];
            if (client_valid_in[i] && !client_ifc_in[i].first) begin
                w_bad_head = 1'b1;
            end
        end
    end

    // Round-robin search starting at rr_ptr; the candidate index wraps explicitly so odd client counts work.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + CW1'(k);
            if (w_cand >= CW1'(NUM_CLIENTS)) begin
                w_cand = w_cand - CW1'(NUM_CLIENTS);
            end
            if (!w_found && w_elig[w_cand[CW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[CW-1:0];
            end
        end
    end

    // Next-state and datapath: grant in IDLE, pass-through in SEND, fixed idle gap so shim status settles.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_dst_nxt   = r_dst;
        w_gap_nxt   = r_gap_cnt;
        w_err_nxt   = r_err;
        w_ready     = '0;
        w_accept    = 1'b0;
        w_ifc       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_bad_head) begin
                    w_err_nxt = 1'b1;
                end
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_dst_nxt   = client_ifc_in[w_winner].dst_port;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_ready[r_grant] = ~shim_full_in[r_dst];
                w_accept         = client_valid_in[r_grant] & w_ready[r_grant];
                if (w_accept) begin
                    w_ifc = client_ifc_in[r_grant];
                    if (w_ifc.last) begin
                        w_rr_nxt    = (r_grant == CW'(NUM_CLIENTS - 1)) ? '0 : r_grant + 1'b1;
                        w_gap_nxt   = GW'(GAP_CYCLES - 1);
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; reset mid-packet drops the lock and restarts arbitration at client 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_dst     <= '0;
            r_gap_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_dst     <= w_dst_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign client_ready_out = w_ready;
    assign shim_wren_out    = w_accept;
    assign shim_ifc_out     = w_ifc;
    assign grant_out        = r_grant;
    assign busy_out         = (r_state != ST_IDLE);
    assign err_protocol_out = r_err;

endmodule

// File: tb/tb_shim_inject_arbiter.sv
module tb_shim_inject_arbiter;
    import shim_inject_pkg::*;

    localparam int NC = 4;
    localparam int NP = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    SwitchInterface client_ifc_in [NC];
    logic [NC-1:0]  client_valid_in;
    logic [NC-1:0]  client_ready_out;
    SwitchInterface shim_ifc_out;
    logic           shim_wren_out;
    logic [NP-1:0]  shim_full_in;
    logic [1:0]     grant_out;
    logic           busy_out;
    logic           err_protocol_out;

    shim_inject_arbiter #(.NUM_CLIENTS(NC), .NUM_PORTS(NP), .GAP_CYCLES(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .client_ifc_in    (client_ifc_in),
        .client_valid_in  (client_valid_in),
        .client_ready_out (client_ready_out),
        .shim_ifc_out     (shim_ifc_out),
        .shim_wren_out    (shim_wren_out),
        .shim_full_in     (shim_full_in),
        .grant_out        (grant_out),
        .busy_out         (busy_out),
        .err_protocol_out (err_protocol_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    SwitchInterface q [NC][$];
    logic [31:0]    log_dat [$];
    int             log_cyc [$];
    logic [NP-1:0]  full_v;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_dat(input int c, input int p, input int i);
        return 32'((c << 12) | (p << 4) | i);
    endfunction

    task automatic push_pkt(input int c, input int dst, input int n, input int p);
        SwitchInterface ph;
        for (int i = 0; i < n; i++) begin
            ph.first    = (i == 0);
            ph.last     = (i == n - 1);
            ph.dst_port = 3'(dst);
            ph.data     = mk_dat(c, p, i);
            q[c].push_back(ph);
        end
    endtask

    // One cycle: drive queue heads at the falling edge, settle, log forwarded phits, pop accepted ones.
    task automatic step();
        @(negedge clk);
        shim_full_in = full_v;
        for (int c = 0; c < NC; c++) begin
            client_valid_in[c] = (q[c].size() > 0);
            client_ifc_in[c]   = (q[c].size() > 0) ? q[c][0] : '0;
        end
        #1;
        cyc++;
        if (shim_wren_out) begin
            log_dat.push_back(shim_ifc_out.data);
            log_cyc.push_back(cyc);
        end
        for (int c = 0; c < NC; c++) begin
            if (client_valid_in[c] && client_ready_out[c]) void'(q[c].pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < NC; c++) q[c].delete();
        full_v          = '0;
        shim_full_in    = '0;
        client_valid_in = '0;
        for (int c = 0; c < NC; c++) client_ifc_in[c] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_dat.delete();
        log_cyc.delete();
        cyc = 0;
    endtask

    initial begin
        full_v          = '0;
        shim_full_in    = '0;
        client_valid_in = '0;
        for (int c = 0; c < NC; c++) client_ifc_in[c] = '0;

        // Reset state, with live requests that must not leak through
        #2;
        client_valid_in = '1;
        for (int c = 0; c < NC; c++) client_ifc_in[c] = '{first: 1'b1, last: 1'b1, dst_port: 3'(c), data: 32'hABCD};
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(client_ready_out), 64'h0);
        chk("rst_wren", 64'(shim_wren_out), 64'h0);
        chk("rst_grant", 64'(grant_out), 64'h0);
        chk("rst_busy", 64'(busy_out), 64'h0);
        chk("rst_err", 64'(err_protocol_out), 64'h0);
        chk("rst_ifc", 64'(shim_ifc_out), 64'h0);

        // Single client 0, 3-phit packet to port 5
        do_reset();
        push_pkt(0, 5, 3, 1);
        step();
        chk("t1_idle_wren", 64'(shim_wren_out), 64'h0);
        chk("t1_idle_rdy", 64'(client_ready_out), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t1_wren%0d", i), 64'(shim_wren_out), 64'h1);
            chk($sformatf("t1_dat%0d", i), 64'(shim_ifc_out.data), 64'(mk_dat(0, 1, i)));
            chk($sformatf("t1_last%0d", i), 64'(shim_ifc_out.last), 64'(i == 2));
        end
        step();
        chk("t1_gap1_wren", 64'(shim_wren_out), 64'h0);
        chk("t1_gap1_busy", 64'(busy_out), 64'h1);
        chk("t1_gap1_ifc", 64'(shim_ifc_out), 64'h0);
        step();
        chk("t1_gap2_busy", 64'(busy_out), 64'h1);
        step();
        chk("t1_t6_busy", 64'(busy_out), 64'h0);

        // Round-robin across all four clients, with wrap back to client 0
        do_reset();
        push_pkt(0, 1, 1, 1);
        push_pkt(0, 1, 1, 2);
        push_pkt(1, 2, 1, 1);
        push_pkt(2, 3, 1, 1);
        push_pkt(3, 4, 1, 1);
        for (int i = 0; i < 25; i++) step();
        chk("t2_count", 64'(log_dat.size()), 64'd5);
        if (log_dat.size() == 5) begin
            chk("t2_c0", 64'(log_dat[0]), 64'(mk_dat(0, 1, 0)));
            chk("t2_c1", 64'(log_dat[1]), 64'(mk_dat(1, 1, 0)));
            chk("t2_c2", 64'(log_dat[2]), 64'(mk_dat(2, 1, 0)));
            chk("t2_c3", 64'(log_dat[3]), 64'(mk_dat(3, 1, 0)));
            chk("t2_wrap_c0", 64'(log_dat[4]), 64'(mk_dat(0, 2, 0)));
            chk("t2_first_cyc", 64'(log_cyc[0]), 64'd2);
            chk("t2_period", 64'(log_cyc[4] - log_cyc[3]), 64'd4);
        end

        // Full destination skipped; blocked client granted once its port frees
        do_reset();
        full_v[2] = 1'b1;
        push_pkt(1, 2, 1, 1);
        push_pkt(2, 3, 1, 1);
        step();
        chk("t3_idle_rdy", 64'(client_ready_out), 64'h0);
        step();
        chk("t3_grant2", 64'(grant_out), 64'd2);
        chk("t3_dat2", 64'(shim_ifc_out.data), 64'(mk_dat(2, 1, 0)));
        step();
        step();
        full_v[2] = 1'b0;
        step();
        step();
        chk("t3_grant1", 64'(grant_out), 64'd1);
        chk("t3_wren1", 64'(shim_wren_out), 64'h1);
        chk("t3_dat1", 64'(shim_ifc_out.data), 64'(mk_dat(1, 1, 0)));

        // Mid-packet stall on port 6 for four cycles
        do_reset();
        push_pkt(0, 6, 4, 3);
        step();
        step();
        chk("t4_p0_wren", 64'(shim_wren_out), 64'h1);
        full_v[6] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t4_stall_rdy%0d", i), 64'(client_ready_out), 64'h0);
            chk($sformatf("t4_stall_wren%0d", i), 64'(shim_wren_out), 64'h0);
        end
        full_v[6] = 1'b0;
        step();
        chk("t4_resume_wren", 64'(shim_wren_out), 64'h1);
        for (int i = 0; i < 4; i++) step();
        chk("t4_count", 64'(log_dat.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_dat.size(); i++)
            chk($sformatf("t4_dat%0d", i), 64'(log_dat[i]), 64'(mk_dat(0, 3, i)));

        // Head without first in IDLE: sticky error, never granted
        do_reset();
        q[3].push_back('{first: 1'b0, last: 1'b1, dst_port: 3'd0, data: 32'h77});
        step();
        chk("t5_err_pre", 64'(err_protocol_out), 64'h0);
        step();
        chk("t5_err_set", 64'(err_protocol_out), 64'h1);
        q[3].delete();
        for (int i = 0; i < 4; i++) step();
        chk("t5_err_sticky", 64'(err_protocol_out), 64'h1);
        chk("t5_no_grant", 64'(log_dat.size()), 64'd0);
        chk("t5_busy", 64'(busy_out), 64'h0);
        do_reset();
        chk("t5_err_clr", 64'(err_protocol_out), 64'h0);

        // Reset during phit 2 of a 4-phit packet from client 1
        push_pkt(1, 0, 4, 4);
        step();
        step();
        chk("t6_grant1", 64'(grant_out), 64'd1);
        step();
        chk("t6_p1_wren", 64'(shim_wren_out), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wren", 64'(shim_wren_out), 64'h0);
        chk("t6_rst_grant", 64'(grant_out), 64'h0);
        chk("t6_rst_rdy", 64'(client_ready_out), 64'h0);
        q[1].delete();
        @(negedge clk);
        rst_n = 1'b1;
        log_dat.delete();
        push_pkt(2, 3, 1, 5);
        push_pkt(0, 4, 1, 5);
        step();
        step();
        chk("t6_post_grant", 64'(grant_out), 64'd0);
        chk("t6_post_dat", 64'(shim_ifc_out.data), 64'(mk_dat(0, 5, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
